// File: rtl/sdp_y_core_triosy_pkg.sv
// Shared types and default sizing for the SDP Y-core cfg triosy wait controller.
package sdp_y_core_triosy_pkg;

    // Default sizing: object count, watchdog width/limit, retired-transaction counter width
    localparam int unsigned N_OBJ_DEF   = 32'd8;
    localparam int unsigned TMO_W_DEF   = 32'd10;
    localparam int unsigned TIMEOUT_DEF = 32'd1000;
    localparam int unsigned CNT_W_DEF   = 32'd16;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETIRE = 2'd3
    } triosy_state_e;

    // True while a transaction occupies the controller (core must stall)
    function automatic logic state_is_busy(input triosy_state_e st);
        logic busy;
        case (st)
            IDLE:    busy = 1'b0;
            ISSUE:   busy = 1'b1;
            WAIT:    busy = 1'b1;
            RETIRE:  busy = 1'b1;
            default: busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/sdp_y_core_triosy_ack_slice.sv
// Per-object bookkeeping: remembers whether this object takes part in the
// current transaction and whether its bawt has been seen, and drives its
// biwt/bdwt pulses from that registered state only.
module sdp_y_core_triosy_ack_slice (
    input  logic nvdla_core_clk,
    input  logic nvdla_core_rst,
    input  logic load_en,
    input  logic load_bit,
    input  logic issue_en,
    input  logic collect_en,
    input  logic retire_en,
    input  logic bawt,
    output logic biwt,
    output logic bdwt,
    output logic complete
);

    logic pend_r;
    logic acked_r;

    // Participation bit: captured on request accept, dropped once retired
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            pend_r <= 1'b0;
        end else if (load_en) begin
            pend_r <= load_bit;
        end else if (retire_en) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= pend_r;
        end
    end

    // Ack bit: cleared on accept, accumulates bawt (only while pending) in ISSUE/WAIT
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            acked_r <= 1'b0;
        end else if (load_en) begin
            acked_r <= 1'b0;
        end else if (collect_en) begin
            acked_r <= acked_r | (bawt & pend_r);
        end else begin
            acked_r <= acked_r;
        end
    end

    // Pulses decode from registered state; completion feeds next-state logic only
    always_comb begin
        biwt     = issue_en & pend_r;
        bdwt     = retire_en & pend_r;
        complete = (~pend_r) | acked_r | bawt;
    end

endmodule

// File: rtl/sdp_y_core_cfg_triosy_wait_ctrl.sv
// Upstream controller for the SDP Y-core cfg triosy wait datapaths.
// Issues biwt to each selected object, collects bawt, retires all selected
// objects with a single bdwt pulse and reports completion to the core.
// A watchdog forces retirement of a stuck transaction and flags a sticky error.
module sdp_y_core_cfg_triosy_wait_ctrl
    import sdp_y_core_triosy_pkg::*;
#(
    parameter int unsigned N_OBJ   = N_OBJ_DEF,
    parameter int unsigned TMO_W   = TMO_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             req_vld,
    input  logic [N_OBJ-1:0] req_mask,
    output logic             req_rdy,
    output logic             core_stall,
    output logic             done_pulse,
    output logic [N_OBJ-1:0] obj_biwt,
    output logic [N_OBJ-1:0] obj_bdwt,
    input  logic [N_OBJ-1:0] obj_bawt,
    input  logic             err_clr,
    output logic             err_timeout,
    output logic [CNT_W-1:0] xact_cnt
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 32'd1);

    triosy_state_e    state_r;
    triosy_state_e    state_nxt_s;
    logic [TMO_W-1:0] tmo_r;
    logic [CNT_W-1:0] xact_cnt_r;
    logic             err_timeout_r;
    logic             zero_done_r;

    logic             idle_s;
    logic             issue_s;
    logic             wait_s;
    logic             retire_s;
    logic             collect_s;
    logic             accept_s;
    logic             zero_req_s;
    logic             all_done_s;
    logic             tmo_hit_s;
    logic [N_OBJ-1:0] complete_s;

    // Per-object pend/ack tracking
    for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_obj
        sdp_y_core_triosy_ack_slice u_slice (
            .nvdla_core_clk (nvdla_core_clk),
            .nvdla_core_rst (nvdla_core_rst),
            .load_en        (accept_s),
            .load_bit       (req_mask[gi]),
            .issue_en       (issue_s),
            .collect_en     (collect_s),
            .retire_en      (retire_s),
            .bawt           (obj_bawt[gi]),
            .biwt           (obj_biwt[gi]),
            .bdwt           (obj_bdwt[gi]),
            .complete       (complete_s[gi])
        );
    end

    // State decode and request qualification
    always_comb begin
        idle_s     = (state_r == IDLE);
        issue_s    = (state_r == ISSUE);
        wait_s     = (state_r == WAIT);
        retire_s   = (state_r == RETIRE);
        collect_s  = issue_s | wait_s;
        accept_s   = idle_s & req_vld & (|req_mask);
        zero_req_s = idle_s & req_vld & ~(|req_mask);
        all_done_s = &complete_s;
        tmo_hit_s  = wait_s & ~all_done_s & (tmo_r == TMO_LAST);
    end

    // FSM state register
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (all_done_s) begin
                    state_nxt_s = RETIRE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (all_done_s || tmo_hit_s) begin
                    state_nxt_s = RETIRE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RETIRE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from registered state only
    always_comb begin
        req_rdy     = idle_s;
        core_stall  = state_is_busy(state_r);
        done_pulse  = retire_s | zero_done_r;
        err_timeout = err_timeout_r;
        xact_cnt    = xact_cnt_r;
    end

    // Zero-mask requests complete on the following cycle without touching objects
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            zero_done_r <= 1'b0;
        end else begin
            zero_done_r <= zero_req_s;
        end
    end

    // Watchdog: restarts on accept, counts every WAIT cycle
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if (accept_s) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if (wait_s) begin
            tmo_r <= tmo_r + TMO_W'(1);
        end else begin
            tmo_r <= tmo_r;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            err_timeout_r <= 1'b0;
        end else if (tmo_hit_s) begin
            err_timeout_r <= 1'b1;
        end else if (err_clr) begin
            err_timeout_r <= 1'b0;
        end else begin
            err_timeout_r <= err_timeout_r;
        end
    end

    // Retired-transaction counter, wraps silently
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            xact_cnt_r <= {CNT_W{1'b0}};
        end else if (done_pulse) begin
            xact_cnt_r <= xact_cnt_r + CNT_W'(1);
        end else begin
            xact_cnt_r <= xact_cnt_r;
        end
    end

endmodule

// File: tb/tb_sdp_y_core_cfg_triosy_wait_ctrl.sv
// Self-checking bench for sdp_y_core_cfg_triosy_wait_ctrl.
// Expected timing comes from a per-transaction model: retire happens the
// cycle after the last selected object acks (never before cycle 2), or after
// TIMEOUT WAIT cycles if some object never acks.
module tb_sdp_y_core_cfg_triosy_wait_ctrl;

    localparam int TIMEOUT = 1000;
    localparam int NEVER   = 1000000;

    logic        nvdla_core_clk = 1'b0;
    logic        nvdla_core_rst;
    logic        req_vld;
    logic [7:0]  req_mask;
    logic        req_rdy;
    logic        core_stall;
    logic        done_pulse;
    logic [7:0]  obj_biwt;
    logic [7:0]  obj_bdwt;
    logic [7:0]  obj_bawt;
    logic        err_clr;
    logic        err_timeout;
    logic [15:0] xact_cnt;

    int          checks = 0;
    int          passed = 0;
    logic [15:0] model_cnt;
    logic        model_err;
    int          ack_at[8];

    sdp_y_core_cfg_triosy_wait_ctrl dut (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .req_vld        (req_vld),
        .req_mask       (req_mask),
        .req_rdy        (req_rdy),
        .core_stall     (core_stall),
        .done_pulse     (done_pulse),
        .obj_biwt       (obj_biwt),
        .obj_bdwt       (obj_bdwt),
        .obj_bawt       (obj_bawt),
        .err_clr        (err_clr),
        .err_timeout    (err_timeout),
        .xact_cnt       (xact_cnt)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    // One full transaction; entered and left just after a rising edge.
    task automatic run_xact(input logic [7:0] mask, input logic [7:0] noise,
                            input logic clr, input string tag);
        int          max_a;
        int          exp_ret;
        logic        tmo_exp;
        logic        exp_err;
        logic [7:0]  b;
        logic [18:0] got;
        logic [18:0] exp;
        max_a = 1;
        for (int i = 0; i < 8; i++) begin
            if (mask[i] && ack_at[i] > max_a) max_a = ack_at[i];
        end
        tmo_exp = (max_a > 1 + TIMEOUT);
        exp_ret = (tmo_exp ? 1 + TIMEOUT : max_a) + 1;

        req_vld  = 1'b1;
        req_mask = mask;
        err_clr  = clr;
        obj_bawt = noise & ~mask;
        @(negedge nvdla_core_clk);
        checks++;
        if (req_rdy !== 1'b1 || core_stall !== 1'b0) begin
            $display("FAIL %s accept: rdy=%b stall=%b expected rdy=1 stall=0", tag, req_rdy, core_stall);
        end else passed++;
        @(posedge nvdla_core_clk); #1;

        for (int cyc = 1; cyc <= exp_ret; cyc++) begin
            req_vld  = 1'($urandom_range(0, 1));
            req_mask = 8'($urandom);
            b = noise & ~mask;
            for (int i = 0; i < 8; i++) begin
                if (mask[i] && cyc >= ack_at[i]) b[i] = 1'b1;
            end
            obj_bawt = b;
            @(negedge nvdla_core_clk);
            exp = {(cyc == 1) ? mask : 8'h00, (cyc == exp_ret) ? mask : 8'h00,
                   (cyc == exp_ret), 1'b1, 1'b0};
            got = {obj_biwt, obj_bdwt, done_pulse, core_stall, req_rdy};
            checks++;
            if (got !== exp) begin
                $display("FAIL %s c%0d {biwt,bdwt,done,stall,rdy}: got %h expected %h", tag, cyc, got, exp);
            end else passed++;
            if (cyc == exp_ret) begin
                exp_err = tmo_exp ? 1'b1 : (clr ? 1'b0 : model_err);
                checks++;
                if (err_timeout !== exp_err) begin
                    $display("FAIL %s retire err_timeout: got %b expected %b", tag, err_timeout, exp_err);
                end else passed++;
            end
            @(posedge nvdla_core_clk); #1;
        end

        req_vld   = 1'b0;
        req_mask  = 8'h00;
        err_clr   = 1'b0;
        obj_bawt  = 8'h00;
        model_cnt = model_cnt + 16'd1;
        model_err = clr ? 1'b0 : (tmo_exp | model_err);
        @(negedge nvdla_core_clk);
        checks++;
        if (req_rdy !== 1'b1 || core_stall !== 1'b0 || done_pulse !== 1'b0 ||
            xact_cnt !== model_cnt || err_timeout !== model_err) begin
            $display("FAIL %s after: rdy=%b stall=%b done=%b cnt=%h err=%b expected 1 0 0 %h %b",
                     tag, req_rdy, core_stall, done_pulse, xact_cnt, err_timeout, model_cnt, model_err);
        end else passed++;
        @(posedge nvdla_core_clk); #1;
    endtask

    task automatic test_reset();
        nvdla_core_rst = 1'b1;
        req_vld  = 1'b0;
        req_mask = 8'h00;
        obj_bawt = 8'h00;
        err_clr  = 1'b0;
        model_cnt = 16'd0;
        model_err = 1'b0;
        #2;
        checks++;
        if ({obj_biwt, obj_bdwt, done_pulse, core_stall, req_rdy, err_timeout, xact_cnt} !==
            {8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
            $display("FAIL reset_state: biwt=%h bdwt=%h done=%b stall=%b rdy=%b err=%b cnt=%h expected 00 00 0 0 1 0 0000",
                     obj_biwt, obj_bdwt, done_pulse, core_stall, req_rdy, err_timeout, xact_cnt);
        end else passed++;
        repeat (2) @(posedge nvdla_core_clk);
        #1;
        nvdla_core_rst = 1'b0;
        @(negedge nvdla_core_clk);
        checks++;
        if (req_rdy !== 1'b1 || core_stall !== 1'b0 || done_pulse !== 1'b0 || xact_cnt !== 16'h0000) begin
            $display("FAIL reset_release: rdy=%b stall=%b done=%b cnt=%h expected 1 0 0 0000",
                     req_rdy, core_stall, done_pulse, xact_cnt);
        end else passed++;
        @(posedge nvdla_core_clk); #1;
    endtask

    task automatic test_single();
        for (int i = 0; i < 8; i++) ack_at[i] = NEVER;
        ack_at[0] = 1;
        run_xact(8'h01, 8'h00, 1'b0, "single");
    endtask

    task automatic test_multi();
        for (int i = 0; i < 8; i++) ack_at[i] = NEVER;
        ack_at[0] = 1; ack_at[1] = 3; ack_at[2] = 5; ack_at[3] = 4;
        run_xact(8'h0F, 8'h00, 1'b0, "multi");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) ack_at[i] = $urandom_range(1, 9);
            run_xact(8'($urandom_range(1, 255)), 8'($urandom), 1'b0, "random");
        end
    endtask

    task automatic test_nonpend();
        for (int i = 0; i < 8; i++) ack_at[i] = NEVER;
        ack_at[1] = 7;
        run_xact(8'h02, 8'hFD, 1'b0, "nonpend");
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 8; i++) ack_at[i] = NEVER;
        run_xact(8'h80, 8'h00, 1'b0, "timeout");
    endtask

    task automatic test_err_clr();
        err_clr = 1'b1;
        @(negedge nvdla_core_clk);
        checks++;
        if (err_timeout !== 1'b1) begin
            $display("FAIL err_before_clr: got %b expected 1", err_timeout);
        end else passed++;
        @(posedge nvdla_core_clk); #1;
        err_clr = 1'b0;
        model_err = 1'b0;
        @(negedge nvdla_core_clk);
        checks++;
        if (err_timeout !== 1'b0) begin
            $display("FAIL err_clr: got %b expected 0", err_timeout);
        end else passed++;
        @(posedge nvdla_core_clk); #1;
        // err_clr held through a timeout: the set must win on the timeout cycle
        for (int i = 0; i < 8; i++) ack_at[i] = NEVER;
        run_xact(8'h80, 8'h00, 1'b1, "timeout_clr");
    endtask

    task automatic test_zero_mask(input int n, input string tag);
        logic [18:0] got;
        req_vld  = 1'b1;
        req_mask = 8'h00;
        @(negedge nvdla_core_clk);
        checks++;
        if (done_pulse !== 1'b0 || req_rdy !== 1'b1) begin
            $display("FAIL %s c0: done=%b rdy=%b expected 0 1", tag, done_pulse, req_rdy);
        end else passed++;
        for (int k = 1; k <= n; k++) begin
            @(posedge nvdla_core_clk); #1;
            if (k == n) req_vld = 1'b0;
            @(negedge nvdla_core_clk);
            got = {obj_biwt, obj_bdwt, done_pulse, core_stall, req_rdy};
            checks++;
            if (got !== {8'h00, 8'h00, 1'b1, 1'b0, 1'b1}) begin
                $display("FAIL %s c%0d {biwt,bdwt,done,stall,rdy}: got %h expected %h",
                         tag, k, got, {8'h00, 8'h00, 1'b1, 1'b0, 1'b1});
            end else passed++;
        end
        @(posedge nvdla_core_clk); #1;
        model_cnt = model_cnt + 16'(n);
        @(negedge nvdla_core_clk);
        checks++;
        if (done_pulse !== 1'b0 || xact_cnt !== model_cnt) begin
            $display("FAIL %s end: done=%b cnt=%h expected 0 %h", tag, done_pulse, xact_cnt, model_cnt);
        end else passed++;
        @(posedge nvdla_core_clk); #1;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) ack_at[i] = NEVER;
        ack_at[0] = 1;
        req_vld  = 1'b1;
        req_mask = 8'h33;
        @(posedge nvdla_core_clk); #1;
        req_vld = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            obj_bawt = (cyc >= 1) ? 8'h01 : 8'h00;
            @(negedge nvdla_core_clk);
            if (cyc < 4) begin
                @(posedge nvdla_core_clk); #1;
            end
        end
        checks++;
        if (core_stall !== 1'b1) begin
            $display("FAIL rst_mid pre: stall=%b expected 1", core_stall);
        end else passed++;
        nvdla_core_rst = 1'b1;
        #1;
        model_cnt = 16'd0;
        model_err = 1'b0;
        checks++;
        if ({obj_biwt, obj_bdwt, done_pulse, core_stall, req_rdy, xact_cnt} !==
            {8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0000}) begin
            $display("FAIL rst_mid immediate: biwt=%h bdwt=%h done=%b stall=%b rdy=%b cnt=%h expected 00 00 0 0 1 0000",
                     obj_biwt, obj_bdwt, done_pulse, core_stall, req_rdy, xact_cnt);
        end else passed++;
        repeat (2) @(posedge nvdla_core_clk);
        #1;
        nvdla_core_rst = 1'b0;
        obj_bawt = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge nvdla_core_clk);
            checks++;
            if (obj_bdwt !== 8'h00 || done_pulse !== 1'b0 || req_rdy !== 1'b1) begin
                $display("FAIL rst_mid post c%0d: bdwt=%h done=%b rdy=%b expected 00 0 1",
                         k, obj_bdwt, done_pulse, req_rdy);
            end else passed++;
            @(posedge nvdla_core_clk); #1;
        end
        for (int i = 0; i < 8; i++) ack_at[i] = 2 + i;
        run_xact(8'h33, 8'h00, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_random();
        test_nonpend();
        test_timeout();
        test_err_clr();
        test_zero_mask(1, "zero_mask");
        test_zero_mask(3, "zero_b2b");
        test_zero_mask(int'(16'hFFFF - model_cnt), "zero_to_ffff");
        test_zero_mask(1, "zero_wrap");
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
